if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the `pc` register.
- Takes the current `pc`, fetches the instruction word from an instruction memory over a req/ack handshake, and queues {pc, instr} pairs in a small FIFO for decode.
- Generates `pc_we`, which lets the `pc` register load `npc` only when a fetch completes, so pc advances exactly once per accepted instruction.
- `redirect` flushes the queue and any in-flight fetch on branch/jump.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pc  in  32  current pc from the `pc` register
- pc_we  out  1  pc load enable; `pc` register loads `npc` at the edge where this is 1
- redirect  in  1  one-cycle flush pulse; the pc source is overwritten at the same edge
- imem_req  out  1  fetch request, registered state decode
- imem_addr  out  32  fetch address, equal to `pc` (combinational)
- imem_ack  in  1  fetch complete; may assert in the first req cycle
- imem_rdata  in  32  instruction word, valid when `imem_ack`=1
- instr_valid  out  1  queue head valid (count≠0)
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  32  head pc

Behaviour:
- Reset asserted (async): state=IDLE, count=0, rd/wr pointers=0, `imem_req`=0, `pc_we`=0, `instr_valid`=0. `instr` and `instr_pc` are don't-care while invalid.
- Reset deassert is sampled synchronously; the first req can be asserted at the 2nd edge after deassert.
- Terms:
  - pop = `instr_valid` & `instr_ready`
  - done = `imem_req` & `imem_ack`
  - count_next = count + push − pop, or 0 on `redirect`
- States: IDLE, REQ, DROP. `imem_req` = (state==REQ | state==DROP).
- IDLE:
  - `redirect`=0 and count_next<DEPTH → REQ; otherwise stay in IDLE.
- REQ:
  - done & `redirect`=0:
    - push {`pc`, `imem_rdata`}; `pc_we`=1 this cycle (combinational).
    - Next state REQ if count_next<DEPTH (back-to-back fetch; `imem_addr` follows the updated `pc` next cycle), else IDLE.
  - done & `redirect`=1: discard data, no push, `pc_we`=0 → IDLE.
  - no done & `redirect`=1 → DROP.
  - no done & `redirect`=0: hold REQ; `imem_addr` must stay stable, since `pc` does not change while `pc_we`=0.
- DROP:
  - Keeps `imem_req`=1 until done.
  - Discards `imem_rdata`, `pc_we`=0, no push → IDLE.
  - `redirect` in DROP: stay in DROP semantics.
- `pc_we` is 1 only in the REQ & done & !`redirect` case. Exactly one `pc_we` cycle per pushed entry.
- FIFO:
  - Push at wr_ptr, pop at rd_ptr; pointers wrap modulo DEPTH.
  - Simultaneous push and pop keeps count unchanged, including at count=DEPTH−1.
  - Pop with count=0 is impossible because `instr_valid`=0.
  - Invariant: push never occurs with count==DEPTH.
- Redirect:
  - count←0 and pointers←0 at the edge.
  - `instr_valid`=0 the next cycle.
  - A pop in the same cycle as `redirect` is still considered consumed by decode.
- Order: entries leave in fetch order; `instr_pc` equals the pc used for that fetch.
- Reset mid-fetch abandons the transaction. The memory side must tolerate the dropped req.

Test Plan:
- Zero-wait memory (ack = req), `pc` model 0x3000 +4 on `pc_we`, `instr_ready`=1:
  - First `instr_valid` 2 cycles after reset release.
  - Then one instruction per cycle: `instr_pc`=0x3000, 0x3004, 0x3008…, `instr`=mem[pc].
- `instr_ready`=0, zero-wait memory, DEPTH=2:
  - Exactly 2 pushes (0x3000, 0x3004), then `imem_req` drops and `pc` holds at 0x3008.
  - Raising `instr_ready` drains in order and fetching resumes at 0x3008.
- Memory with 3-cycle ack latency:
  - `imem_addr` stable at 0x3000 for 3 cycles, one `pc_we` pulse, entry {0x3000, word}.
  - No duplicate pushes.
- `redirect` in REQ 1 cycle before ack, with `pc` loaded to 0x4000:
  - State DROP, the late ack data is discarded, no `pc_we`, queue empty.
  - Next fetch address is 0x4000.
- `redirect` coinciding with ack and with a pending pop:
  - Nothing pushed, count=0 next cycle, `instr_valid`=0.
  - Fetch restarts from the new pc.
- Assert reset during REQ with 1 entry queued:
  - `imem_req`, `instr_valid` and `pc_we` are 0 immediately (asynchronously).
  - After release, fetch restarts from the current `pc`.

Source files
------------

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction fetch over a req/ack memory port into a small
//            {pc, instr} FIFO for decode, with pc advance and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_we,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic w_done;
    logic w_push;
    logic w_pop;
    logic w_fits;

    assign imem_req    = (r_state == c_REQ) || (r_state == c_DROP);
    assign imem_addr   = pc;
    assign w_done      = imem_req && imem_ack;
    assign w_push      = (r_state == c_REQ) && w_done && !redirect;
    assign pc_we       = w_push;
    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid && instr_ready;
    assign instr       = r_mem_instr[r_rd_ptr];
    assign instr_pc    = r_mem_pc[r_rd_ptr];

    always_comb begin
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        if (redirect) begin
            w_count_next = '0;
        end
    end

    assign w_fits = (w_count_next < c_DEPTH);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (!redirect && w_fits) begin
                    w_state_next = c_REQ;
                end
            end
            c_REQ: begin
                if (w_done) begin
                    w_state_next = (!redirect && w_fits) ? c_REQ : c_IDLE;
                end else if (redirect) begin
                    // the outstanding fetch must still complete before a new one
                    w_state_next = c_DROP;
                end
            end
            c_DROP: begin
                if (w_done) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // storage needs no reset: contents are only observed behind instr_valid
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
